// File: rtl/vx_wb_arbiter_pkg.sv
// Shared types and constants for the writeback commit arbiter.
package vx_wb_arbiter_pkg;

  typedef enum logic {
    ArbUnlocked = 1'b0,
    ArbLocked   = 1'b1
  } arb_state_e;

  localparam int unsigned NumReqsDefault = 4;

  // Index width, never narrower than one bit so a single requester still has a port.
  function automatic int unsigned req_bits(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_wb_arbiter_rr_select.sv
// Combinational round-robin picker: first eligible index at or after i_start, wrapping.
module vx_wb_arbiter_rr_select
  import vx_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS = NumReqsDefault,
  parameter int unsigned REQ_BITS = req_bits(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] i_eligible,
  input  logic [REQ_BITS-1:0] i_start,
  output logic [NUM_REQS-1:0] o_grant,
  output logic [REQ_BITS-1:0] o_idx,
  output logic                o_valid
);

  int unsigned w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      w_pos = 32'(i_start) + k;
      if (w_pos >= NUM_REQS) w_pos = w_pos - NUM_REQS;
      if (!o_valid && i_eligible[REQ_BITS'(w_pos)]) begin
        o_valid                     = 1'b1;
        o_idx                       = REQ_BITS'(w_pos);
        o_grant[REQ_BITS'(w_pos)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_wb_arbiter.sv
// Writeback arbiter: round-robin over commit streams, locked across multi-packet writebacks.
// Optional per-requester stall counters are enabled with the PERF_WB_ARB_EN macro.
module vx_wb_arbiter
  import vx_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS   = NumReqsDefault,
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned REQ_BITS  = req_bits(NUM_REQS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQS-1:0]                 i_req_valid,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQS-1:0]                 i_req_eop,
  output logic [NUM_REQS-1:0]                 o_req_ready,
  output logic                                o_wb_valid,
  output logic [DATA_WIDTH-1:0]               o_wb_data,
  output logic                                o_wb_eop,
  output logic [REQ_BITS-1:0]                 o_wb_idx,
  input  logic                                i_wb_ready
`ifdef PERF_WB_ARB_EN
  ,
  output logic [NUM_REQS-1:0][31:0]           o_perf_stall
`endif
);

  localparam logic [REQ_BITS-1:0] LastIdx = REQ_BITS'(NUM_REQS - 1);

  arb_state_e              r_state, w_state_next;
  logic [REQ_BITS-1:0]     r_lock_idx, w_lock_idx_next;
  logic [REQ_BITS-1:0]     r_last_grant, w_last_grant_next;
  logic [REQ_BITS-1:0]     w_start, w_sel_idx;
  logic [NUM_REQS-1:0]     w_eligible, w_grant;
  logic                    w_sel_valid, w_can_load, w_fire;
  logic                    r_wb_valid, r_wb_eop;
  logic [DATA_WIDTH-1:0]   r_wb_data;
  logic [REQ_BITS-1:0]     r_wb_idx;

  assign w_start    = (r_last_grant == LastIdx) ? '0 : r_last_grant + 1'b1;
  // While locked only the owner of the open writeback may compete.
  assign w_eligible = (r_state == ArbLocked) ?
                      (i_req_valid & (NUM_REQS'(1) << r_lock_idx)) : i_req_valid;

  vx_wb_arbiter_rr_select #(
    .NUM_REQS (NUM_REQS),
    .REQ_BITS (REQ_BITS)
  ) u_rr_select (
    .i_eligible (w_eligible),
    .i_start    (w_start),
    .o_grant    (w_grant),
    .o_idx      (w_sel_idx),
    .o_valid    (w_sel_valid)
  );

  assign w_can_load  = ~r_wb_valid | i_wb_ready;
  assign w_fire      = w_sel_valid & w_can_load & ~reset;
  assign o_req_ready = w_fire ? w_grant : '0;

  always_comb begin
    w_state_next      = r_state;
    w_lock_idx_next   = r_lock_idx;
    w_last_grant_next = r_last_grant;
    if (w_fire) begin
      if (i_req_eop[w_sel_idx]) begin
        w_state_next      = ArbUnlocked;
        w_last_grant_next = w_sel_idx;
      end else begin
        w_state_next    = ArbLocked;
        w_lock_idx_next = w_sel_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ArbUnlocked;
      r_lock_idx   <= '0;
      r_last_grant <= LastIdx;
      r_wb_valid   <= 1'b0;
      r_wb_eop     <= 1'b0;
      r_wb_data    <= '0;
      r_wb_idx     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_lock_idx   <= w_lock_idx_next;
      r_last_grant <= w_last_grant_next;
      if (w_can_load) r_wb_valid <= w_fire;
      if (w_fire) begin
        r_wb_data <= i_req_data[w_sel_idx];
        r_wb_eop  <= i_req_eop[w_sel_idx];
        r_wb_idx  <= w_sel_idx;
      end
    end
  end

  assign o_wb_valid = r_wb_valid;
  assign o_wb_data  = r_wb_data;
  assign o_wb_eop   = r_wb_eop;
  assign o_wb_idx   = r_wb_idx;

`ifdef PERF_WB_ARB_EN
  logic [NUM_REQS-1:0][31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        if (i_req_valid[i] && !o_req_ready[i] && (r_perf_stall[i] != '1)) begin
          r_perf_stall[i] <= r_perf_stall[i] + 32'd1;
        end
      end
    end
  end

  assign o_perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Scoreboard bench for vx_wb_arbiter: grant model, packet queue and scenario tasks.
module tb_vx_wb_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req_valid, req_eop, req_ready;
  logic [N-1:0][DW-1:0] req_data;
  logic                 wb_valid, wb_eop, wb_ready;
  logic [DW-1:0]        wb_data;
  logic [1:0]           wb_idx;
`ifdef PERF_WB_ARB_EN
  logic [N-1:0][31:0]   perf_stall;
`endif

  vx_wb_arbiter #(
    .NUM_REQS   (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .i_req_eop    (req_eop),
    .o_req_ready  (req_ready),
    .o_wb_valid   (wb_valid),
    .o_wb_data    (wb_data),
    .o_wb_eop     (wb_eop),
    .o_wb_idx     (wb_idx),
    .i_wb_ready   (wb_ready)
`ifdef PERF_WB_ARB_EN
    ,
    .o_perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            idx;
  } pkt_t;

  pkt_t         pkt_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           seq = 0;
  bit           m_locked;
  int           m_lock_idx;
  int           m_last;
  bit           m_wbv;
  logic [N-1:0] g_ready;

  task automatic set_data();
    seq++;
    for (int i = 0; i < N; i++) req_data[i] = {32'(seq), 32'(i)};
  endtask

  // One clock: model/scoreboard checks at the falling edge, then advance past the rising edge.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    int           gi;
    bit           can;
    pkt_t         p;
    @(negedge clk);
    g_ready = req_ready;
    if (reset) begin
      n_cmp++;
      if (req_ready !== '0) begin
        n_bad++;
        $display("FAIL ready_in_reset: got %b want 0000", req_ready);
      end
      m_locked = 0; m_lock_idx = 0; m_last = N - 1; m_wbv = 0;
      pkt_q.delete();
    end else begin
      can       = !m_wbv || wb_ready;
      exp_ready = '0;
      gi        = -1;
      for (int k = 0; k < N; k++) begin
        int j = (m_last + 1 + k) % N;
        if (gi < 0 && req_valid[j] && (!m_locked || j == m_lock_idx)) gi = j;
      end
      if (gi >= 0 && can) exp_ready[gi] = 1'b1;
      n_cmp++;
      if (req_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL req_ready: got %b want %b", req_ready, exp_ready);
      end
      n_cmp++;
      if (wb_valid !== m_wbv) begin
        n_bad++;
        $display("FAIL wb_valid: got %b want %b", wb_valid, m_wbv);
      end
      if (m_wbv && wb_ready) begin
        n_cmp++;
        if (pkt_q.size() == 0) begin
          n_bad++;
          $display("FAIL wb_packet: got packet idx %0d want none queued", wb_idx);
        end else begin
          p = pkt_q.pop_front();
          if (wb_data !== p.d || wb_eop !== p.e || wb_idx !== 2'(p.idx)) begin
            n_bad++;
            $display("FAIL wb_packet: got d=%h e=%b i=%0d want d=%h e=%b i=%0d",
                     wb_data, wb_eop, wb_idx, p.d, p.e, p.idx);
          end
        end
      end
      if (gi >= 0 && can) begin
        p.d = req_data[gi]; p.e = req_eop[gi]; p.idx = gi;
        pkt_q.push_back(p);
        if (req_eop[gi]) begin
          m_locked = 0; m_last = gi;
        end else begin
          m_locked = 1; m_lock_idx = gi;
        end
        m_wbv = 1;
      end else if (can) begin
        m_wbv = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    wb_ready  = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; req_eop = '1; wb_ready = 1'b1;
    set_data();
    cycle();
    cycle();
    n_cmp++;
    if (wb_valid !== 1'b0 || wb_eop !== 1'b0 || wb_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got v=%b e=%b i=%0d want 0 0 0", wb_valid, wb_eop, wb_idx);
    end
    n_cmp++;
    if (wb_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", wb_data);
    end
    reset = 1'b0; req_valid = '0;
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    req_valid = '1; req_eop = '1; wb_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_data();
      cycle();
      n_cmp++;
      if (g_ready !== (4'b0001 << exp_g[c])) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: got %b want idx %0d", c, g_ready, exp_g[c]);
      end
      n_cmp++;
      if (wb_idx !== 2'(exp_g[c])) begin
        n_bad++;
        $display("FAIL rr_wb_idx[%0d]: got %0d want %0d", c, wb_idx, exp_g[c]);
      end
    end
    drain();
  endtask

  task automatic test_lock_contiguous();
    int exp_g[4] = '{1, 1, 1, 2};
    req_valid = 4'b0111; req_eop = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      req_eop[1] = (c == 2);
      set_data();
      cycle();
      n_cmp++;
      if (g_ready !== (4'b0001 << exp_g[c])) begin
        n_bad++;
        $display("FAIL lock_grant[%0d]: got %b want idx %0d", c, g_ready, exp_g[c]);
      end
      n_cmp++;
      if (wb_idx !== 2'(exp_g[c])) begin
        n_bad++;
        $display("FAIL lock_wb_idx[%0d]: got %0d want %0d", c, wb_idx, exp_g[c]);
      end
      if (c == 2) req_valid[1] = 1'b0;
    end
    drain();
  endtask

  task automatic test_lock_hold();
    req_valid = 4'b0010; req_eop = 4'b0000;
    set_data();
    cycle();
    n_cmp++;
    if (g_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL hold_open: got %b want 0010", g_ready);
    end
    req_valid = 4'b1000; req_eop = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      set_data();
      cycle();
      n_cmp++;
      if (g_ready !== 4'b0000 || wb_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_block[%0d]: got ready=%b v=%b want 0000 0", c, g_ready, wb_valid);
      end
    end
    req_valid = 4'b1010; req_eop = 4'b1010;
    set_data();
    cycle();
    n_cmp++;
    if (g_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL hold_close: got %b want 0010", g_ready);
    end
    set_data();
    cycle();
    n_cmp++;
    if (g_ready !== 4'b1000) begin
      n_bad++;
      $display("FAIL hold_next: got %b want 1000", g_ready);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    req_valid = 4'b0001; req_eop = 4'b0001; wb_ready = 1'b1;
    set_data();
    held = req_data[0];
    cycle();
    wb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_cmp++;
      if (g_ready !== 4'b0000 || wb_valid !== 1'b1 || wb_data !== held) begin
        n_bad++;
        $display("FAIL stall[%0d]: got ready=%b v=%b d=%h want 0000 1 %h",
                 c, g_ready, wb_valid, wb_data, held);
      end
    end
    wb_ready = 1'b1; req_valid = '0;
    cycle();
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_release: got v=%b want 0", wb_valid);
    end
    drain();
  endtask

  task automatic test_reset_mid_lock();
    req_valid = 4'b0100; req_eop = 4'b0000;
    set_data();
    cycle();
    n_cmp++;
    if (g_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL midlock_open: got %b want 0100", g_ready);
    end
    reset = 1'b1; req_valid = 4'b0101; req_eop = 4'b0101;
    set_data();
    cycle();
    reset = 1'b0;
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midlock_flush: got v=%b want 0", wb_valid);
    end
    cycle();
    n_cmp++;
    if (g_ready !== 4'b0001 || wb_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL midlock_first: got ready=%b idx=%0d want 0001 0", g_ready, wb_idx);
    end
    drain();
  endtask

`ifdef PERF_WB_ARB_EN
  task automatic test_perf();
    reset = 1'b1; req_valid = '0;
    cycle();
    reset = 1'b0;
    req_valid = 4'b0010; req_eop = 4'b0000;
    set_data();
    cycle();
    req_valid = 4'b1000; req_eop = 4'b1000;
    for (int c = 0; c < 7; c++) cycle();
    n_cmp++;
    if (perf_stall[3] !== 32'd7) begin
      n_bad++;
      $display("FAIL perf_stall3: got %0d want 7", perf_stall[3]);
    end
    req_valid = 4'b0010; req_eop = 4'b0010;
    cycle();
    drain();
  endtask
`endif

  initial begin
    reset = 1'b1; req_valid = '0; req_eop = '0; wb_ready = 1'b1; req_data = '0;
    m_locked = 0; m_lock_idx = 0; m_last = N - 1; m_wbv = 0; g_ready = '0;
    test_reset();
    test_round_robin();
    test_lock_contiguous();
    test_lock_hold();
    test_backpressure();
    test_reset_mid_lock();
`ifdef PERF_WB_ARB_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vx_wb_arbiter.md
VX_WB_ARBITER -- requirements
Module: VX_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of execution-unit commit streams (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 64: opaque writeback payload (wid, PC, rd, data, uuid packed by caller).
REQ-003 SHALL have localparam REQ_BITS = max(1, clog2(NUM_REQS)).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQS  per-requester packet valid.
REQ-007 req_data  input  NUM_REQS x DATA_WIDTH  per-requester payload.
REQ-008 req_eop  input  NUM_REQS  last packet of a multi-packet writeback.
REQ-009 req_ready  output  NUM_REQS  per-requester accept; at most one bit high per cycle.
REQ-010 wb_valid  output  1  registered writeback valid toward scoreboard/GPR.
REQ-011 wb_data  output  DATA_WIDTH  registered payload.
REQ-012 wb_eop  output  1  registered end-of-packet; scoreboard releases rd only on wb_eop.
REQ-013 wb_idx  output  REQ_BITS  index of requester owning the current wb packet.
REQ-014 wb_ready  input  1  downstream accept.

Function
REQ-015 Transfer on a requester port when req_valid[i] && req_ready[i]; on wb port when wb_valid && wb_ready.
REQ-016 Output stage is a single register; latency from accepted request to wb_valid is exactly 1 cycle.
REQ-017 Output stage can load when ~wb_valid || wb_ready (full throughput, one packet per cycle).
REQ-018 req_ready[i] = (i == selected) && req_valid[i] && output stage can load; never high for an invalid requester.
REQ-019 Unlocked selection is round-robin: search starts at (last_grant + 1) mod NUM_REQS; last_grant updates only on an accepted packet with req_eop = 1.
REQ-020 Lock: two states UNLOCKED/LOCKED; accepted packet with req_eop = 0 -> LOCKED on that index; in LOCKED only the locked index is eligible; accepted packet from locked index with req_eop = 1 -> UNLOCKED.
REQ-021 In LOCKED with locked requester deasserting req_valid, no other requester SHALL be granted (packets of one writeback never interleave).
REQ-022 wb_data/wb_eop/wb_idx SHALL hold stable while wb_valid && ~wb_ready.
REQ-023 NUM_REQS = 1: arbiter degenerates to a registered pass-through, lock still tracked, wb_idx = 0.
REQ-024 Single requester valid while unlocked SHALL be granted the same cycle regardless of pointer position.

Reset
REQ-025 On reset: wb_valid = 0, wb_eop = 0, wb_idx = 0, wb_data = 0, state = UNLOCKED, last_grant = NUM_REQS-1 (so requester 0 has first priority), req_ready all 0 during reset.
REQ-026 Reset asserted mid-lock SHALL drop the lock and the in-flight output packet; no partial packet appears after reset.

Configuration
REQ-027 Macro PERF_WB_ARB_EN: when defined, adds output perf_stall  NUM_REQS x 32: counter i increments each cycle req_valid[i] && ~req_ready[i], saturates at 2^32-1, cleared by reset; when undefined the port and counters do not exist.

Structure
REQ-028 VX_gpu_pkg SHALL hold the lock-state enum (ARB_UNLOCKED, ARB_LOCKED) and the default NUM_REQS constant.
REQ-029 Round-robin selection SHALL be a sub-module VX_rr_select (inputs: eligible mask, start pointer; outputs: one-hot grant, index, valid), purely combinational.

Verification
REQ-030 All 4 requesters valid, all eop=1, wb_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; wb_idx follows one cycle later.
REQ-031 Req1 sends 3 packets (eop=0,0,1) while req0/req2 valid -> wb_idx = 1,1,1 contiguous, then grant 2.
REQ-032 Req1 locked, req1 drops valid 5 cycles, req3 valid -> req_ready[3] = 0 for all 5 cycles, wb_valid = 0.
REQ-033 wb_ready = 0 for 3 cycles with req0 valid -> wb_data constant, req_ready all 0, one packet delivered after release.
REQ-034 Reset asserted while locked on req2 -> next cycle wb_valid = 0, state UNLOCKED; req0 granted first after reset.
REQ-035 PERF_WB_ARB_EN defined, req3 blocked 7 cycles by lock -> perf_stall[3] = 7.
